pc_sequencer: RTL

Owns the fetch program counter for the 5-stage core and sequences control-flow redirects resolved by the branch-target ALU in EX. It compares the EX-stage target against the fall-through address to decide whether a redirect is needed. It then drives redirect, wrong-path flush and fetch-stall controls for the IF/ID and ID/EX pipeline registers.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences EX-resolved control-flow redirects into PC loads, wrong-path flushes and fetch stalls.
// Optional PC_SEQ_STATS_EN adds saturating ctrl_cnt / redirect_cnt statistics outputs.
module pc_sequencer #(
    parameter int                   DATA_SIZE    = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC     = '0,
    parameter int                   FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_is_ctrl,
    input  logic [DATA_SIZE-1:0] ex_pc,
    input  logic [DATA_SIZE-1:0] pc_jump_address,
    input  logic                 hazard_stall,
    input  logic                 imem_ready,
    output logic [DATA_SIZE-1:0] pc,
    output logic [DATA_SIZE-1:0] pc_plus4,
    output logic                 redirect,
    output logic                 flush,
    output logic                 stall_if,
    output logic                 if_bubble
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [31:0]          ctrl_cnt,
    output logic [31:0]          redirect_cnt
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [DATA_SIZE-1:0] PC_STEP  = DATA_SIZE'(4);
    // The redirect cycle itself is the first flush cycle, so FLUSH lasts FLUSH_CYCLES-1 cycles.
    localparam logic [3:0]           CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [DATA_SIZE-1:0]   r_pc;

    state_t                 w_next_state;
    logic [3:0]             w_next_cnt;
    logic [DATA_SIZE-1:0]   w_next_pc;
    logic [DATA_SIZE-1:0]   w_ex_plus4;
    logic [DATA_SIZE-1:0]   w_target;
    logic                   w_taken;

    assign w_ex_plus4 = ex_pc + PC_STEP;
    assign w_target   = {pc_jump_address[DATA_SIZE-1:2], 2'b00};
    assign w_taken    = ex_valid & ex_is_ctrl & (pc_jump_address != w_ex_plus4);
    assign pc         = r_pc;
    assign pc_plus4   = r_pc + PC_STEP;

    always_ff @(posedge clk) begin
        r_state <= w_next_state;
        r_cnt   <= w_next_cnt;
        r_pc    <= w_next_pc;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_pc    = r_pc;
        redirect     = 1'b0;
        flush        = 1'b0;
        stall_if     = 1'b0;
        if_bubble    = 1'b0;
        if (rst) begin
            w_next_state = RUN;
            w_next_cnt   = 4'd0;
            w_next_pc    = RESET_PC;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_taken) begin
                        redirect  = 1'b1;
                        flush     = 1'b1;
                        w_next_pc = w_target;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state = FLUSH;
                            w_next_cnt   = CNT_INIT;
                        end
                    end else if (hazard_stall) begin
                        stall_if = 1'b1;
                    end else if (!imem_ready) begin
                        if_bubble = 1'b1;
                    end else begin
                        w_next_pc = r_pc + PC_STEP;
                    end
                end
                FLUSH: begin
                    // Wrong-path EX content and load-use stalls are irrelevant here.
                    flush = 1'b1;
                    if (imem_ready) begin
                        w_next_pc = r_pc + PC_STEP;
                    end else begin
                        if_bubble = 1'b1;
                    end
                    if (r_cnt == 4'd0) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_STATS_EN
    logic [31:0] r_ctrl_cnt;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_cnt     <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if ((r_state == RUN) && ex_valid && ex_is_ctrl && (r_ctrl_cnt != 32'hFFFF_FFFF)) begin
                r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
            end
            if (redirect && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign ctrl_cnt     = r_ctrl_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
